// File: rtl/mem_arbiter.sv
// Purpose: shares one memory port between IFU (master 0) and LSU (master 1), round-robin on ties.
// Latency: 0-cycle accept in IDLE, mem_req_valid the next cycle, response passed through combinationally.
// Backpressure: one transaction in flight; payload held until mem_req_ready; response stalls on owner's resp_ready.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_req_addr,
  input  logic                    ifu_req_wen,
  input  logic [DATA_WIDTH-1:0]   ifu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] ifu_req_wstrb,
  output logic                    ifu_resp_valid,
  input  logic                    ifu_resp_ready,
  output logic [DATA_WIDTH-1:0]   ifu_resp_rdata,

  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_req_addr,
  input  logic                    lsu_req_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_req_wstrb,
  output logic                    lsu_resp_valid,
  input  logic                    lsu_resp_ready,
  output logic [DATA_WIDTH-1:0]   lsu_resp_rdata,

  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic                    mem_req_wen,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_req_wstrb,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q;       // 0 = IFU, 1 = LSU
  logic   last_grant_q;  // master granted most recently; the other wins a tie
  req_t   pay_q;

  req_t ifu_pay, lsu_pay;
  logic accept;
  logic grant_lsu;
  logic owner_resp_ready;

  assign ifu_pay = {ifu_req_addr, ifu_req_wen, ifu_req_wdata, ifu_req_wstrb};
  assign lsu_pay = {lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wstrb};

  // The memory sees the latched payload directly; it only changes on an accept.
  assign mem_req_addr  = pay_q.addr;
  assign mem_req_wen   = pay_q.wen;
  assign mem_req_wdata = pay_q.wdata;
  assign mem_req_wstrb = pay_q.wstrb;

  assign owner_resp_ready = owner_q ? lsu_resp_ready : ifu_resp_ready;

  // Next-state, grant selection and response routing.
  always_comb begin
    state_d        = state_q;
    accept         = 1'b0;
    grant_lsu      = 1'b0;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    mem_resp_ready = 1'b0;
    ifu_resp_valid = 1'b0;
    ifu_resp_rdata = '0;
    lsu_resp_valid = 1'b0;
    lsu_resp_rdata = '0;

    case (state_q)
      IDLE: begin
        // Reset gates the accept so no ready leaks out while rst is held low.
        if (rst && (ifu_req_valid || lsu_req_valid)) begin
          accept        = 1'b1;
          grant_lsu     = lsu_req_valid && (!ifu_req_valid || !last_grant_q);
          ifu_req_ready = !grant_lsu;
          lsu_req_ready = grant_lsu;
          state_d       = REQ;
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          state_d = RESP;
        end
      end
      RESP: begin
        mem_resp_ready = owner_resp_ready;
        if (owner_q) begin
          lsu_resp_valid = mem_resp_valid;
          lsu_resp_rdata = mem_resp_rdata;
        end else begin
          ifu_resp_valid = mem_resp_valid;
          ifu_resp_rdata = mem_resp_rdata;
        end
        if (mem_resp_valid && owner_resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, ownership and payload registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      pay_q        <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= grant_lsu;
        last_grant_q <= grant_lsu;
        pay_q        <= grant_lsu ? lsu_pay : ifu_pay;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model checks every output each
// cycle, a reactive memory supplies configurable wait states, and literal checks pin
// the key scenarios (single read, alternating grants, backpressure, mid-flight reset).
module tb_mem_arbiter;

  logic        clk;
  logic        rst;

  logic        ifu_req_valid, ifu_req_ready, ifu_req_wen;
  logic [31:0] ifu_req_addr, ifu_req_wdata;
  logic [3:0]  ifu_req_wstrb;
  logic        ifu_resp_valid, ifu_resp_ready;
  logic [31:0] ifu_resp_rdata;

  logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
  logic [31:0] lsu_req_addr, lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_resp_valid, lsu_resp_ready;
  logic [31:0] lsu_resp_rdata;

  logic        mem_req_valid, mem_req_ready, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory behaviour knobs.
  int req_wait  = 0;
  int resp_wait = 0;

  // Logs of what the DUT actually did, for literal checks.
  bit grant_log[$];
  bit wen_log[$];

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_req_wen(ifu_req_wen), .ifu_req_wdata(ifu_req_wdata), .ifu_req_wstrb(ifu_req_wstrb),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_resp_rdata(ifu_resp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_resp_rdata(lsu_resp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ifu_req_ready"},  ifu_req_ready,  0);
    check({tag, "_lsu_req_ready"},  lsu_req_ready,  0);
    check({tag, "_ifu_resp_valid"}, ifu_resp_valid, 0);
    check({tag, "_lsu_resp_valid"}, lsu_resp_valid, 0);
    check({tag, "_ifu_resp_rdata"}, ifu_resp_rdata, 0);
    check({tag, "_lsu_resp_rdata"}, lsu_resp_rdata, 0);
    check({tag, "_mem_req_valid"},  mem_req_valid,  0);
    check({tag, "_mem_resp_ready"}, mem_resp_ready, 0);
    check({tag, "_mem_req_addr"},   mem_req_addr,   0);
    check({tag, "_mem_req_wen"},    mem_req_wen,    0);
    check({tag, "_mem_req_wdata"},  mem_req_wdata,  0);
    check({tag, "_mem_req_wstrb"},  mem_req_wstrb,  0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input bit lsu, input string nm);
    bit got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (lsu ? lsu_req_ready : ifu_req_ready) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: req_ready not seen within 60 cycles (required 1)", nm);
    end
  endtask

  task automatic wait_resp(input bit lsu, input string nm);
    bit got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (lsu ? lsu_resp_valid : ifu_resp_valid) begin
        got = 1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: resp_valid not seen within 60 cycles (required 1)", nm);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a, input logic w);
    if (w) return 32'h0;
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return ~a;
  endfunction

  // Reactive memory: raises ready after req_wait cycles, answers after resp_wait cycles.
  initial begin : memory
    bit          req_hs, resp_hs, mbusy;
    int          mcnt;
    logic [31:0] maddr;
    logic        mwen;
    mem_req_ready  = 0;
    mem_resp_valid = 0;
    mem_resp_rdata = 0;
    mbusy = 0;
    mcnt  = 0;
    maddr = 0;
    mwen  = 0;
    forever begin
      @(negedge clk);
      req_hs  = mem_req_valid && mem_req_ready;
      resp_hs = mem_resp_valid && mem_resp_ready;
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_req_ready  = 0;
        mem_resp_valid = 0;
        mem_resp_rdata = 0;
        mbusy = 0;
        mcnt  = 0;
      end else if (mbusy) begin
        if (resp_hs) begin
          mem_resp_valid = 0;
          mem_resp_rdata = 0;
          mbusy = 0;
          mcnt  = 0;
        end else if (!mem_resp_valid) begin
          if (mcnt >= resp_wait) begin
            mem_resp_valid = 1;
            mem_resp_rdata = mem_data(maddr, mwen);
          end else begin
            mcnt++;
          end
        end
      end else if (req_hs) begin
        mem_req_ready = 0;
        mbusy = 1;
        mcnt  = 0;
        if (resp_wait == 0) begin
          mem_resp_valid = 1;
          mem_resp_rdata = mem_data(maddr, mwen);
        end
      end else if (mem_req_valid) begin
        if (mcnt >= req_wait) begin
          mem_req_ready = 1;
          maddr = mem_req_addr;
          mwen  = mem_req_wen;
        end else begin
          mcnt++;
        end
      end
    end
  end

  // Transaction-level model and per-cycle comparison of every DUT output.
  initial begin : compare
    bit          m_busy, m_issued, m_owner, m_last;
    logic [31:0] m_addr, m_wdata;
    logic        m_wen;
    logic [3:0]  m_wstrb;
    bit          any, win, e_mreq, o_rdy;
    m_busy = 0; m_issued = 0; m_owner = 0; m_last = 0;
    m_addr = 0; m_wdata = 0; m_wen = 0; m_wstrb = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_busy = 0; m_issued = 0; m_owner = 0; m_last = 0;
        check_zero("in_reset");
      end else begin
        any = !m_busy && (ifu_req_valid || lsu_req_valid);
        if (ifu_req_valid && lsu_req_valid) win = !m_last;
        else                                win = lsu_req_valid;
        e_mreq = m_busy && !m_issued;
        o_rdy  = m_owner ? lsu_resp_ready : ifu_resp_ready;

        check("ifu_req_ready", ifu_req_ready, any && !win);
        check("lsu_req_ready", lsu_req_ready, any && win);
        check("mem_req_valid", mem_req_valid, e_mreq);
        if (e_mreq) begin
          check("mem_req_addr",  mem_req_addr,  m_addr);
          check("mem_req_wen",   mem_req_wen,   m_wen);
          check("mem_req_wdata", mem_req_wdata, m_wdata);
          check("mem_req_wstrb", mem_req_wstrb, m_wstrb);
        end
        check("mem_resp_ready", mem_resp_ready, (m_busy && m_issued) ? o_rdy : 1'b0);
        check("ifu_resp_valid", ifu_resp_valid, (m_busy && m_issued && !m_owner) ? mem_resp_valid : 1'b0);
        check("lsu_resp_valid", lsu_resp_valid, (m_busy && m_issued &&  m_owner) ? mem_resp_valid : 1'b0);
        check("ifu_resp_rdata", ifu_resp_rdata, (m_busy && m_issued && !m_owner) ? mem_resp_rdata : 32'h0);
        check("lsu_resp_rdata", lsu_resp_rdata, (m_busy && m_issued &&  m_owner) ? mem_resp_rdata : 32'h0);

        if (ifu_req_ready || lsu_req_ready) grant_log.push_back(lsu_req_ready);
        if (mem_req_valid && mem_req_ready) wen_log.push_back(mem_req_wen);

        // Advance the transaction model across the coming clock edge.
        if (!m_busy) begin
          if (any) begin
            m_busy = 1; m_issued = 0; m_owner = win; m_last = win;
            m_addr  = win ? lsu_req_addr  : ifu_req_addr;
            m_wen   = win ? lsu_req_wen   : ifu_req_wen;
            m_wdata = win ? lsu_req_wdata : ifu_req_wdata;
            m_wstrb = win ? lsu_req_wstrb : ifu_req_wstrb;
          end
        end else if (!m_issued) begin
          if (mem_req_ready) m_issued = 1;
        end else if (mem_resp_valid && o_rdy) begin
          m_busy = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish by 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    bit exp_order[4];
    bit exp_wen[4];
    int vcnt;
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
    exp_wen   = '{1'b1, 1'b0, 1'b1, 1'b0};

    rst = 0;
    ifu_req_valid = 0; ifu_req_addr = 0; ifu_req_wen = 0; ifu_req_wdata = 0; ifu_req_wstrb = 0;
    lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0; lsu_req_wstrb = 0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    #1;
    check_zero("por");
    tick(2);
    rst = 1;
    tick(2);

    // Single IFU read, memory answers after two wait states.
    resp_wait = 2;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0000;
    #1;
    check("s1_ifu_accept_c0", ifu_req_ready, 1);
    check("s1_lsu_no_accept", lsu_req_ready, 0);
    tick(1);
    ifu_req_valid = 0;
    #1;
    check("s1_mem_req_valid_c1", mem_req_valid, 1);
    check("s1_mem_req_addr_c1",  mem_req_addr,  32'h8000_0000);
    wait_resp(0, "s1_resp");
    check("s1_ifu_rdata", ifu_resp_rdata, 32'h0000_0413);
    check("s1_lsu_no_resp", lsu_resp_valid, 0);
    tick(3);

    // Both masters hold requests for four transactions: LSU, IFU, LSU, IFU.
    resp_wait = 0;
    grant_log.delete();
    wen_log.delete();
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_req_addr = 32'h8000_1000; lsu_req_wen = 1;
    lsu_req_wdata = 32'hDEAD_BEEF; lsu_req_wstrb = 4'hF;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (grant_log.size() >= 4) break;
    end
    ifu_req_valid = 0;
    lsu_req_valid = 0;
    tick(10);
    check("s2_grant_count", grant_log.size(), 4);
    check("s2_wen_count", wen_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s2_grant_%0d", i), (i < grant_log.size()) ? grant_log[i] : 1'bx, exp_order[i]);
      check($sformatf("s2_wen_%0d", i),   (i < wen_log.size())   ? wen_log[i]   : 1'bx, exp_wen[i]);
    end

    // Downstream backpressure: five cycles of mem_req_ready low, IFU waiting meanwhile.
    req_wait = 5;
    lsu_req_valid = 1; lsu_req_addr = 32'h1234_5678; lsu_req_wen = 1;
    lsu_req_wdata = 32'hCAFE_F00D; lsu_req_wstrb = 4'h3;
    wait_ready(1, "s3_lsu_accept");
    tick(1);
    lsu_req_valid = 0;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0010;
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_req_valid) break;
      vcnt++;
    end
    check("s3_req_valid_cycles", vcnt, 6);
    wait_ready(0, "s3_ifu_accept");
    tick(1);
    ifu_req_valid = 0;
    tick(12);
    req_wait = 0;

    // Master response backpressure on the LSU for three cycles.
    lsu_resp_ready = 0;
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_2000; lsu_req_wen = 0;
    lsu_req_wdata = 0; lsu_req_wstrb = 0;
    wait_ready(1, "s4_lsu_accept");
    tick(1);
    lsu_req_valid = 0;
    wait_resp(1, "s4_resp");
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("s4_mem_resp_ready_stall%0d", i), mem_resp_ready, 0);
      check($sformatf("s4_lsu_resp_valid_stall%0d", i), lsu_resp_valid, 1);
      check($sformatf("s4_lsu_rdata_stall%0d", i),      lsu_resp_rdata, 32'hFFFF_DFFF);
    end
    tick(1);
    lsu_resp_ready = 1;
    #1;
    check("s4_mem_resp_ready_release", mem_resp_ready, 1);
    check("s4_lsu_rdata_release", lsu_resp_rdata, 32'hFFFF_DFFF);
    tick(3);

    // Reset while the LSU transaction sits in RESP; then a tie must go to the LSU.
    lsu_resp_ready = 0;
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_3000; lsu_req_wen = 0;
    wait_ready(1, "s5_lsu_accept");
    tick(1);
    lsu_req_valid = 0;
    wait_resp(1, "s5_resp");
    #2;
    ifu_req_valid = 1; ifu_req_addr = 32'h8000_0020;
    lsu_req_valid = 1; lsu_req_addr = 32'h0000_4000; lsu_req_wen = 1;
    lsu_req_wdata = 32'h1122_3344; lsu_req_wstrb = 4'hF;
    rst = 0;
    #1;
    check_zero("s5_async_reset");
    tick(2);
    rst = 1;
    lsu_resp_ready = 1;
    #1;
    check("s5_lsu_first_after_reset", lsu_req_ready, 1);
    check("s5_ifu_waits_after_reset", ifu_req_ready, 0);
    tick(1);
    lsu_req_valid = 0;
    wait_ready(0, "s5_ifu_accept");
    tick(1);
    ifu_req_valid = 0;
    tick(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, single-outstanding memory arbiter. It shares one downstream memory port between the instruction fetch unit (IFU, master 0) and the load/store unit (LSU, master 1). Request payloads are registered, and ties are resolved round-robin. The response is routed back to the master that owns the transaction. The block sits between the IFU/LSU stages and the memory/SRAM model.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports (x = ifu | lsu):
- clk  input  1  clock, all state on posedge
- rst  input  1  asynchronous, active-low reset
- x_req_valid  input  1  master request valid
- x_req_ready  output  1  request accepted (single-cycle pulse)
- x_req_addr  input  ADDR_WIDTH  request address
- x_req_wen  input  1  1 = write, 0 = read
- x_req_wdata  input  DATA_WIDTH  write data
- x_req_wstrb  input  DATA_WIDTH/8  byte write strobes
- x_resp_valid  output  1  response valid for this master
- x_resp_ready  input  1  master accepts the response
- x_resp_rdata  output  DATA_WIDTH  read data (0 for writes)
- mem_req_valid  output  1  downstream request valid
- mem_req_ready  input  1  downstream accepts the request
- mem_req_addr / mem_req_wen / mem_req_wdata / mem_req_wstrb  output  as above  registered payload
- mem_resp_valid  input  1  downstream response valid
- mem_resp_ready  output  1  arbiter accepts the response
- mem_resp_rdata  input  DATA_WIDTH  downstream read data

The IFU drives x_req_wen = 0 and wstrb = 0. The arbiter does not check this.

## Operation
- FSM states: IDLE, REQ, RESP. Reset state is IDLE.
- Registers:
  - owner: 0 = IFU, 1 = LSU.
  - last_grant: reset value 0, so the LSU wins the first tie.
  - Payload registers (addr, wen, wdata, wstrb): reset value 0.
- IDLE:
  - If exactly one x_req_valid is set, that master wins.
  - If both are set, the master not equal to last_grant wins.
  - The winner gets x_req_ready = 1 combinationally in this cycle. The loser's ready stays 0.
  - Its payload is latched, owner and last_grant are set to the winner, and the FSM moves to REQ.
  - If no request is pending, the FSM stays in IDLE.
- REQ:
  - mem_req_valid = 1 with the latched payload.
  - On mem_req_ready, move to RESP.
  - The payload is held stable until that handshake.
- RESP:
  - mem_resp_ready = owner's x_resp_ready.
  - owner's x_resp_valid = mem_resp_valid and owner's x_resp_rdata = mem_resp_rdata, combinational passthrough.
  - The non-owner's resp_valid is 0 and its rdata is 0.
  - On a mem_resp_valid && mem_resp_ready handshake, return to IDLE.
- Only one transaction is outstanding at a time. New requests are not acknowledged outside IDLE, and masters hold valid and payload until ready.
- Any mem_resp_valid seen outside RESP is ignored: mem_resp_ready = 0.

## Timing
- Reset (asynchronous, any state, including mid-transaction):
  - The FSM goes to IDLE immediately and last_grant goes to 0.
  - All outputs go to 0: x_req_ready, x_resp_valid, x_resp_rdata, mem_req_valid, mem_resp_ready, and mem_req_* payload.
  - The in-flight transaction is dropped. The downstream must also be reset.
- Accept latency: x_req_ready is asserted in the same cycle as x_req_valid when the FSM is in IDLE (0-cycle accept).
- Issue latency: mem_req_valid rises in the cycle after acceptance.
- Response latency: zero added cycles. x_resp_valid follows mem_resp_valid combinationally.
- Back-to-back operation:
  - A response handshake in cycle M leaves the FSM in IDLE in cycle M+1.
  - The next acceptance can occur in M+1 and the next mem_req_valid in M+2.
  - Peak throughput is one transaction per 3 cycles with a zero-wait-state memory.
- Fairness: under continuous requests from both masters, grants strictly alternate, so neither master waits more than one transaction.
- A single requester is granted every time, regardless of last_grant.
- x_req_ready is never asserted to both masters in the same cycle.
- A master dropping req_valid in IDLE before being granted is legal; nothing is latched.

## Test plan
- Single IFU read: ifu_req_valid=1, addr=0x80000000. Expected: ifu_req_ready in cycle 0, mem_req_valid with addr 0x80000000 in cycle 1. Memory returns rdata=0x00000413 with 2 wait states; ifu_resp_valid/rdata=0x00000413 in the same cycle; the LSU sees no response.
- Simultaneous requests, both held for 4 transactions: IFU addr 0x80000004, LSU write addr 0x80001000, wdata 0xDEADBEEF, wstrb 0xF. Expected grant order LSU, IFU, LSU, IFU. mem_req_wen=1 and wstrb=0xF only on LSU grants.
- Downstream backpressure: mem_req_ready held 0 for 5 cycles in REQ. Expected: mem_req_addr/wdata/wstrb stay stable, no second acceptance, and the request completes after ready rises.
- Master response backpressure: lsu_resp_ready=0 for 3 cycles while mem_resp_valid=1. Expected: mem_resp_ready=0 for those cycles, the FSM stays in RESP, and the handshake completes when lsu_resp_ready rises; the rdata passthrough is unchanged.
- Reset mid-transaction: rst deasserted (driven to 0) while in RESP. Expected: all outputs read 0 immediately without waiting for a clock. After release, a simultaneous IFU/LSU request grants the LSU first.
